// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: NUM_RW byte-strobed control registers plus NUM_RO fabric status registers.
// Optional sticky interrupt status/mask pair enabled by defining AXIL_REGBANK_IRQ_EN.
module axil_regbank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    NUM_RW      = 4,
    parameter int                    NUM_RO      = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                            S_AXI_ACLK,
    input  logic                                            S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]                           S_AXI_AWADDR,
    input  logic [2:0]                                      S_AXI_AWPROT,
    input  logic                                            S_AXI_AWVALID,
    output logic                                            S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                           S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                         S_AXI_WSTRB,
    input  logic                                            S_AXI_WVALID,
    output logic                                            S_AXI_WREADY,
    output logic [1:0]                                      S_AXI_BRESP,
    output logic                                            S_AXI_BVALID,
    input  logic                                            S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                           S_AXI_ARADDR,
    input  logic [2:0]                                      S_AXI_ARPROT,
    input  logic                                            S_AXI_ARVALID,
    output logic                                            S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                           S_AXI_RDATA,
    output logic [1:0]                                      S_AXI_RRESP,
    output logic                                            S_AXI_RVALID,
    input  logic                                            S_AXI_RREADY,
`ifdef AXIL_REGBANK_IRQ_EN
    input  logic [DATA_WIDTH-1:0]                           irq_evt,
    output logic                                            irq,
`endif
    output logic [NUM_RW*DATA_WIDTH-1:0]                    reg_out,
    output logic [NUM_RW-1:0]                               reg_wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_REGBANK_IRQ_EN
    localparam logic [31:0] STAT_IDX = 32'(NUM_RW + NUM_RO);
    localparam logic [31:0] MASK_IDX = 32'(NUM_RW + NUM_RO + 1);
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic [DATA_WIDTH-1:0]     regs [NUM_RW];
    logic [ADDR_WIDTH-1:OFS]   aw_idx_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [NB-1:0]             wstrb_q;
    logic                      aw_hs, w_hs, ar_hs, commit;
    logic [31:0]               cm_idx, rd_idx;
    logic [DATA_WIDTH-1:0]     cm_data, cm_mask, rd_data;
    logic [NB-1:0]             cm_strb;
    logic                      cm_ok;
    logic [1:0]                rd_resp;
    logic                      unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFS-1:0], S_AXI_ARADDR[OFS-1:0]};

    assign S_AXI_AWREADY = (w_state == W_IDLE) || (w_state == W_HAVE_DATA);
    assign S_AXI_WREADY  = (w_state == W_IDLE) || (w_state == W_HAVE_ADDR);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end else if (aw_hs) begin
                    w_next = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: if (w_hs) begin
                w_next = W_RESP;
                commit = 1'b1;
            end
            W_HAVE_DATA: if (aw_hs) begin
                w_next = W_RESP;
                commit = 1'b1;
            end
            W_RESP: if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Whichever half arrived first comes from the holding registers; the other is live on the bus.
    always_comb begin
        cm_idx  = (w_state == W_HAVE_ADDR) ? 32'(aw_idx_q) : 32'(S_AXI_AWADDR[ADDR_WIDTH-1:OFS]);
        cm_data = (w_state == W_HAVE_DATA) ? wdata_q : S_AXI_WDATA;
        cm_strb = (w_state == W_HAVE_DATA) ? wstrb_q : S_AXI_WSTRB;
        cm_mask = '0;
        for (int b = 0; b < NB; b++) cm_mask[b*8 +: 8] = {8{cm_strb[b]}};
        cm_ok   = (cm_idx < 32'(NUM_RW));
`ifdef AXIL_REGBANK_IRQ_EN
        if (cm_idx == STAT_IDX || cm_idx == MASK_IDX) cm_ok = 1'b1;
`endif
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:OFS];
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_RW; k++) regs[k] <= RESET_VALUE;
            reg_wr_pulse <= '0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else begin
            for (int k = 0; k < NUM_RW; k++) begin
                reg_wr_pulse[k] <= commit && (cm_idx == 32'(k));
                if (commit && cm_idx == 32'(k))
                    regs[k] <= (regs[k] & ~cm_mask) | (cm_data & cm_mask);
            end
            if (commit) S_AXI_BRESP <= cm_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_reg_out
        assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

`ifdef AXIL_REGBANK_IRQ_EN
    logic [DATA_WIDTH-1:0] irq_status, irq_mask, irq_clr;

    assign irq_clr = (commit && cm_idx == STAT_IDX) ? (cm_data & cm_mask) : '0;

    // New events win over a same-cycle clear so no event is ever lost.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            irq_status <= '0;
            irq_mask   <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | irq_evt;
            if (commit && cm_idx == MASK_IDX)
                irq_mask <= (irq_mask & ~cm_mask) | (cm_data & cm_mask);
            irq <= |(irq_status & irq_mask);
        end
    end
`endif

    always_comb begin
        rd_idx  = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:OFS]);
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            if (rd_idx == 32'(k)) begin
                rd_data = regs[k];
                rd_resp = RESP_OKAY;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (rd_idx == 32'(NUM_RW + j)) begin
                rd_data = status_in[j*DATA_WIDTH +: DATA_WIDTH];
                rd_resp = RESP_OKAY;
            end
        end
`ifdef AXIL_REGBANK_IRQ_EN
        if (rd_idx == STAT_IDX) begin
            rd_data = irq_status;
            rd_resp = RESP_OKAY;
        end
        if (rd_idx == MASK_IDX) begin
            rd_data = irq_mask;
            rd_resp = RESP_OKAY;
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RDATA <= rd_data;
            S_AXI_RRESP <= rd_resp;
        end
    end
endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank: vector table for single transactions plus hand-written
// sequences for split AW/W ordering, response back-pressure, mid-transaction reset and IRQ.
module tb_axil_regbank;
    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [127:0] reg_out;
    logic [3:0]  reg_wr_pulse;
    logic [63:0] status_in;
`ifdef AXIL_REGBANK_IRQ_EN
    logic [31:0] irq_evt;
    logic        irq;
    localparam logic [1:0] IRQ_RESP = 2'b00;
`else
    localparam logic [1:0] IRQ_RESP = 2'b10;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axil_regbank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
`ifdef AXIL_REGBANK_IRQ_EN
        .irq_evt(irq_evt), .irq(irq),
`endif
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
    );

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [3:0]  exp_pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit wr, logic [5:0] a, logic [31:0] d, logic [3:0] s,
                                logic [31:0] ed, logic [1:0] er, logic [3:0] ep);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s;
        v.exp_data = ed; v.exp_resp = er; v.exp_pulse = ep;
        return v;
    endfunction

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [3:0] pulse, output bit ok);
        bit aw_done = 0, w_done = 0, got = 0;
        bit a_r, w_r;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            a_r = awready && awvalid;
            w_r = wready && wvalid;
            @(posedge clk); #1;
            if (a_r) begin aw_done = 1; awvalid = 1'b0; end
            if (w_r) begin w_done = 1; wvalid = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = 2'bxx; pulse = 4'bxxxx;
        bready = 1'b1;
        n = 0;
        while ((aw_done && w_done) && !got && n < 50) begin
            @(negedge clk);
            if (bvalid) begin resp = bresp; pulse = reg_wr_pulse; got = 1; end
            @(posedge clk); #1;
            n++;
        end
        bready = 1'b0;
        ok = got;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat, output bit ok);
        bit done = 0, got = 0, rdy;
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            rdy = arready;
            @(posedge clk); #1;
            if (rdy) done = 1;
            n++;
        end
        arvalid = 1'b0;
        d = 'x; resp = 'x;
        rready = 1'b1;
        lat = 0;
        while (done && !got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (rvalid) begin d = rdata; resp = rresp; got = 1; end
            @(posedge clk); #1;
        end
        rready = 1'b0;
        ok = got;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, {awready, wready, arready}, 3'b111);
        chk({tag, "_valid"}, {bvalid, rvalid}, 2'b00);
        chk({tag, "_resp"}, {bresp, rresp}, 4'b0000);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_pulse"}, reg_wr_pulse, 4'h0);
        chk({tag, "_regs"}, reg_out[63:0] | reg_out[127:64], 64'h0);
    endtask

    initial begin
        logic [31:0] d, first;
        logic [1:0]  r;
        logic [3:0]  p;
        bit ok, stable;
        int lat;

        rstn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        status_in = {32'h5A5A0001, 32'hA5A5A5A5};
`ifdef AXIL_REGBANK_IRQ_EN
        irq_evt = '0;
`endif

        vecs.push_back(mk(1, 6'h00, 32'h1, 4'hF, 0, 2'b00, 4'b0001));
        vecs.push_back(mk(1, 6'h04, 32'h2, 4'hF, 0, 2'b00, 4'b0010));
        vecs.push_back(mk(1, 6'h08, 32'h3, 4'hF, 0, 2'b00, 4'b0100));
        vecs.push_back(mk(1, 6'h0C, 32'h4, 4'hF, 0, 2'b00, 4'b1000));
        vecs.push_back(mk(0, 6'h00, 0, 0, 32'h1, 2'b00, 0));
        vecs.push_back(mk(0, 6'h04, 0, 0, 32'h2, 2'b00, 0));
        vecs.push_back(mk(0, 6'h08, 0, 0, 32'h3, 2'b00, 0));
        vecs.push_back(mk(0, 6'h0E, 0, 0, 32'h4, 2'b00, 0));
        vecs.push_back(mk(1, 6'h00, 32'hFFFFFFFF, 4'hF, 0, 2'b00, 4'b0001));
        vecs.push_back(mk(1, 6'h00, 32'h12345678, 4'h5, 0, 2'b00, 4'b0001));
        vecs.push_back(mk(0, 6'h00, 0, 0, 32'hFF34FF78, 2'b00, 0));
        vecs.push_back(mk(0, 6'h10, 0, 0, 32'hA5A5A5A5, 2'b00, 0));
        vecs.push_back(mk(1, 6'h10, 32'h11111111, 4'hF, 0, 2'b10, 4'b0000));
        vecs.push_back(mk(0, 6'h10, 0, 0, 32'hA5A5A5A5, 2'b00, 0));
        vecs.push_back(mk(0, 6'h14, 0, 0, 32'h5A5A0001, 2'b00, 0));
        vecs.push_back(mk(0, 6'h3C, 0, 0, 32'h0, 2'b10, 0));
        vecs.push_back(mk(1, 6'h20, 32'h99, 4'hF, 0, 2'b10, 4'b0000));
        vecs.push_back(mk(1, 6'h04, 32'hFFFFFFFF, 4'h0, 0, 2'b00, 4'b0010));
        vecs.push_back(mk(0, 6'h04, 0, 0, 32'h2, 2'b00, 0));
        vecs.push_back(mk(1, 6'h18, 32'h0, 4'hF, 0, IRQ_RESP, 4'b0000));
        vecs.push_back(mk(0, 6'h18, 0, 0, 32'h0, IRQ_RESP, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("init");
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, p, ok);
                chk($sformatf("v%0d_wr_done", i), ok, 1'b1);
                chk($sformatf("v%0d_bresp", i), r, vecs[i].exp_resp);
                chk($sformatf("v%0d_pulse", i), p, vecs[i].exp_pulse);
            end else begin
                do_read(vecs[i].addr, d, r, lat, ok);
                chk($sformatf("v%0d_rd_done", i), ok, 1'b1);
                chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
                chk($sformatf("v%0d_rresp", i), r, vecs[i].exp_resp);
                chk($sformatf("v%0d_rlat", i), lat, 1);
            end
        end

        // W three cycles ahead of AW
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); chk("wfirst_wready", wready, 1'b1);
        @(posedge clk); #1; wvalid = 1'b0;
        stable = 1;
        repeat (3) begin
            @(negedge clk);
            stable &= !bvalid && !wready && awready;
            @(posedge clk); #1;
        end
        chk("wfirst_wait", stable, 1'b1);
        awaddr = 6'h04; awvalid = 1'b1;
        @(negedge clk); chk("wfirst_no_early_b", bvalid, 1'b0);
        @(posedge clk); #1; awvalid = 1'b0;
        @(negedge clk);
        chk("wfirst_b", {bvalid, bresp, reg_wr_pulse}, {1'b1, 2'b00, 4'b0010});
        chk("wfirst_reg1", reg_out[63:32], 32'hDEADBEEF);
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;

        // AW three cycles ahead of W, after clearing reg1
        do_write(6'h04, 32'h0, 4'hF, r, p, ok);
        chk("clr_reg1", reg_out[63:32], 32'h0);
        awaddr = 6'h04; awvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0;
        stable = 1;
        repeat (3) begin
            @(negedge clk);
            stable &= !bvalid && !awready && wready;
            @(posedge clk); #1;
        end
        chk("awfirst_wait", stable, 1'b1);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); chk("awfirst_no_early_b", bvalid, 1'b0);
        @(posedge clk); #1; wvalid = 1'b0;
        @(negedge clk);
        chk("awfirst_b", {bvalid, bresp, reg_wr_pulse}, {1'b1, 2'b00, 4'b0010});
        chk("awfirst_reg1", reg_out[63:32], 32'hDEADBEEF);
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;

        // BREADY held low for 10 cycles
        awaddr = 6'h08; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bhold_pulse_first", reg_wr_pulse, 4'b0100);
        stable = 1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            stable &= bvalid && (bresp == 2'b00) && !awready && !wready;
            if (c > 0) stable &= (reg_wr_pulse == 4'b0000);
            awvalid = 1'b1; wvalid = 1'b1;
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0;
        end
        chk("bhold_stable", stable, 1'b1);
        chk("bhold_reg2", reg_out[95:64], 32'h55);
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
        @(negedge clk);
        chk("bhold_release", {bvalid, awready, wready}, 3'b011);

        // RREADY held low for 10 cycles
        araddr = 6'h00; arvalid = 1'b1;
        @(posedge clk); #1; arvalid = 1'b0;
        @(negedge clk);
        first = rdata;
        chk("rhold_first", {rvalid, rresp, first}, {1'b1, 2'b00, 32'hFF34FF78});
        stable = 1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            arvalid = 1'b1; araddr = 6'h10;
            @(negedge clk);
            stable &= rvalid && (rdata == first) && (rresp == 2'b00) && !arready;
        end
        arvalid = 1'b0;
        chk("rhold_stable", stable, 1'b1);
        @(posedge clk); #1; rready = 1'b1;
        @(posedge clk); #1; rready = 1'b0;
        @(negedge clk);
        chk("rhold_release", {rvalid, arready}, 2'b01);

`ifdef AXIL_REGBANK_IRQ_EN
        do_write(6'h1C, 32'h8, 4'hF, r, p, ok);
        chk("irq_mask_resp", r, 2'b00);
        @(posedge clk); #1; irq_evt = 32'h8;
        @(posedge clk); #1; irq_evt = 32'h0;
        @(posedge clk); #1;
        @(negedge clk); chk("irq_set", irq, 1'b1);
        do_write(6'h18, 32'h8, 4'hF, r, p, ok);
        chk("irq_clr_resp", r, 2'b00);
        @(negedge clk); chk("irq_cleared", irq, 1'b0);
        do_read(6'h18, d, r, lat, ok);
        chk("irq_status_rd", d, 32'h0);
`endif

        // Reset while holding an address with no data
        awaddr = 6'h0C; awvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0;
        @(negedge clk);
        chk("haddr_state", {awready, wready}, 2'b01);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1; rstn = 1'b1;
        do_write(6'h0C, 32'h77, 4'hF, r, p, ok);
        chk("post_rst_wr", {ok, r, p}, {1'b1, 2'b00, 4'b1000});
        do_read(6'h0C, d, r, lat, ok);
        chk("post_rst_rd", {ok, r, d}, {1'b1, 2'b00, 32'h77});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
